mem_port_arbiter: RTL

Shares the single-port unified instruction/data memory between three requesters: the program loader (port 0), the controller's data path for LWI/SWI (port 1), and the controller's instruction fetch (port 2). A small FSM accepts one transaction at a time, latches its command, drives the memory port, waits the fixed memory latency and returns read data with a one-cycle done pulse.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port unified instruction/data memory between three
//   requesters: port 0 = program loader, port 1 = data path (LWI/SWI),
//   port 2 = instruction fetch. One transaction at a time: IDLE arbitrates
//   and latches the winner's command, ISSUE drives the memory strobe,
//   WAIT covers the MEM_LAT read latency, DONE pulses completion.
//
//   Arbitration: the loader always wins; data and fetch alternate
//   round-robin when both request (data is favoured after reset).
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req[2:0]          per-port request level
//   we[2:0]           per-port write enable, sampled with req
//   addr[3*ADDR_W]    per-port word address, port i at [i*ADDR_W +: ADDR_W]
//   wdata[3*DATA_W]   per-port write data,   port i at [i*DATA_W +: DATA_W]
//   gnt[2:0]          one-hot grant pulse (ISSUE cycle)
//   done[2:0]         one-hot completion pulse (DONE cycle)
//   rdata             registered read data, held after done
//   busy              high whenever not IDLE
//   mem_en/mem_we     memory strobes, only in ISSUE
//   mem_addr/wdata    latched command towards memory
//   mem_rdata         memory read data
//
// Optional build macro ARB_STATS_EN adds:
//   stat_clr          synchronous clear of all grant counters
//   stat_cnt[47:0]    saturating 16-bit grant counter per port, port i at [i*16 +: 16]
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
`ifdef ARB_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [47:0]           stat_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        lat_we;
  logic [1:0]  port;
  logic [1:0]  win;
  logic        fav_fetch;   // 1: fetch wins the next data/fetch tie
  logic [2:0]  port_oh;

  // Winner selection; only meaningful when |req.
  always_comb begin
    win = 2'd0;
    if (req[0])
      win = 2'd0;
    else if (req[1] && req[2])
      win = fav_fetch ? 2'd2 : 2'd1;
    else if (req[1])
      win = 2'd1;
    else
      win = 2'd2;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = lat_we ? S_DONE : S_WAIT;
      S_WAIT:  if (wait_cnt == 4'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      port      <= 2'd0;
      fav_fetch <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (|req) begin
            port      <= win;
            lat_we    <= we[win];
            mem_addr  <= addr[win*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[win*DATA_W +: DATA_W];
            // Loader grants leave the data/fetch pointer untouched.
            if (win != 2'd0)
              fav_fetch <= (win == 2'd1);
          end
        end
        S_ISSUE: wait_cnt <= LAT_INIT;
        S_WAIT: begin
          if (wait_cnt == 4'd0)
            rdata <= mem_rdata;
          else
            wait_cnt <= wait_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign port_oh   = 3'b001 << port;
  assign gnt       = (state == S_ISSUE) ? port_oh : 3'b000;
  assign done      = (state == S_DONE)  ? port_oh : 3'b000;
  assign busy      = (state != S_IDLE);
  assign mem_en    = (state == S_ISSUE);
  assign mem_we    = (state == S_ISSUE) && lat_we;

`ifdef ARB_STATS_EN
  logic [15:0] cnt [3];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (reset || stat_clr)
        cnt[i] <= '0;
      else if (gnt[i] && (cnt[i] != 16'hFFFF))
        cnt[i] <= cnt[i] + 16'd1;
    end
  end

  assign stat_cnt = {cnt[2], cnt[1], cnt[0]};
`endif

endmodule
